mem_req_scheduler: RTL and testbench

MEM_REQ_SCHEDULER -- requirements
Module: mem_req_scheduler

---
 rtl/mem_req_pkg.sv | 22 ++
 rtl/mem_req_fifo.sv | 59 +++++
 rtl/mem_req_scheduler.sv | 133 +++++++++++++
 tb/tb_mem_req_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// Shared types and defaults for the memory request scheduler.
package mem_req_pkg;

    localparam int ADDR_W      = 4;
    localparam int DATA_W      = 8;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Request queue: DEPTH-entry FIFO of {rw, addr, wdata} with occupancy count.
module mem_req_fifo
    import mem_req_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  req_t             din,
    output req_t             dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int              PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    req_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_req_scheduler.sv
// Queues SRAM requests and issues them one at a time to a memory controller,
// returning read data and aborting transactions the controller never completes.
module mem_req_scheduler
    import mem_req_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mc_start,
    output logic              mc_rw,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_data_in,
    input  logic [DATA_W-1:0] mc_data_out,
    input  logic              mc_done,
    output logic              busy,
    output logic [2:0]        fifo_count,
    output logic              timeout_err
);

    // state | meaning
    // IDLE  | waiting for a queued request; pops head into mc_* on exit
    // ISSUE | mc_start pulse cycle
    // WAIT  | waiting for mc_done, bounded by the timeout counter
    // RESP  | rsp_valid pulse cycle for a completed read

    localparam int               TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    req_t             push_req;
    req_t             head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             rsp_load;
    logic             abort;
    logic [TMR_W-1:0] wait_cnt;

    assign push_req  = {req_rw, req_addr, req_wdata};
    assign req_ready = !full;
    assign push      = req_valid && req_ready;
    assign busy      = (state != IDLE) || (fifo_count != '0);

    mem_req_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (3)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_req),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        rsp_load  = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                // A completion on the final allowed cycle still wins over the abort.
                if (mc_done) begin
                    rsp_load  = mc_rw;
                    state_nxt = mc_rw ? RESP : IDLE;
                end else if (wait_cnt == TMR_LAST) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_start    <= 1'b0;
            mc_rw       <= 1'b0;
            mc_addr     <= '0;
            mc_data_in  <= '0;
            rsp_valid   <= 1'b0;
            rsp_addr    <= '0;
            rsp_rdata   <= '0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            mc_start  <= pop;
            rsp_valid <= rsp_load;
            if (pop) begin
                mc_rw      <= head.rw;
                mc_addr    <= head.addr;
                mc_data_in <= head.wdata;
            end
            if (state == ISSUE)     wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + TMR_W'(1);
            if (rsp_load) begin
                rsp_addr  <= mc_addr;
                rsp_rdata <= mc_data_out;
            end
            if (abort) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Bench for mem_req_scheduler: behavioural controller plus a queue/array reference model.
module tb_mem_req_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rw = 1'b0;
    logic [3:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready, rsp_valid, mc_start, mc_rw, busy, timeout_err, mc_done;
    logic [3:0] rsp_addr, mc_addr;
    logic [7:0] rsp_rdata, mc_data_in, mc_data_out;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    mem_req_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_addr    (rsp_addr),
        .rsp_rdata   (rsp_rdata),
        .mc_start    (mc_start),
        .mc_rw       (mc_rw),
        .mc_addr     (mc_addr),
        .mc_data_in  (mc_data_in),
        .mc_data_out (mc_data_out),
        .mc_done     (mc_done),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .timeout_err (timeout_err)
    );

    // Behavioural controller: done pulse ctl_lat cycles after start, owns its SRAM.
    logic       ctl_done = 1'b0;
    logic       stray_done = 1'b0;
    logic       ctl_hang = 1'b0;
    int         ctl_lat = 3;
    int         cdn = 0;
    logic       cur_rw;
    logic [3:0] cur_a;
    logic [7:0] cur_d;
    logic [7:0] ctl_dout;
    logic [7:0] sram [16];

    assign mc_done     = ctl_done | stray_done;
    assign mc_data_out = ctl_dout;

    always @(posedge clk) begin
        ctl_done <= 1'b0;
        if (cdn == 1) begin
            ctl_done <= 1'b1;
            if (cur_rw) ctl_dout <= sram[cur_a];
            else        sram[cur_a] <= cur_d;
            cdn <= 0;
        end else if (cdn > 1) begin
            cdn <= cdn - 1;
        end
        if (mc_start && !ctl_hang) begin
            cdn    <= ctl_lat - 1;
            cur_rw <= mc_rw;
            cur_a  <= mc_addr;
            cur_d  <= mc_data_in;
        end
    end

    typedef struct packed {
        logic       rw;
        logic [3:0] addr;
        logic [7:0] d;
    } ent_t;

    ent_t       exp_iss [$];
    logic [7:0] ref_mem [16];
    int         total = 0;
    int         bad = 0;
    int         n_start = 0;
    int         n_rsp = 0;
    bit         pend_rd = 1'b0;
    bit         exp_next = 1'b0;
    bit         prev_start = 1'b0;
    logic [3:0] cur_addr, last_addr;
    logic [7:0] cur_data, last_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    // Monitor: issue order, pulse widths, response timing and read data.
    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            pend_rd    = 1'b0;
            exp_next   = 1'b0;
            prev_start = 1'b0;
        end else begin
            chk("rsp_valid", rsp_valid, exp_next);
            if (rsp_valid && exp_next) begin
                chk("rsp_addr", rsp_addr, cur_addr);
                chk("rsp_rdata", rsp_rdata, cur_data);
                n_rsp++;
                last_addr = rsp_addr;
                last_data = rsp_rdata;
            end
            exp_next = 1'b0;
            if (mc_done && pend_rd) begin
                exp_next = 1'b1;
                pend_rd  = 1'b0;
            end
            if (mc_start) begin
                n_start++;
                chk("start_width", prev_start, 0);
                chk("start_expected", exp_iss.size() != 0, 1);
                if (exp_iss.size() != 0) begin
                    e = exp_iss.pop_front();
                    chk("mc_rw", mc_rw, e.rw);
                    chk("mc_addr", mc_addr, e.addr);
                    chk("mc_data_in", mc_data_in, e.d);
                    if (!ctl_hang) begin
                        if (e.rw) begin
                            pend_rd  = 1'b1;
                            cur_addr = e.addr;
                            cur_data = ref_mem[e.addr];
                        end else begin
                            ref_mem[e.addr] = e.d;
                        end
                    end
                end
            end
            prev_start = mc_start;
        end
    end

    task automatic send(input logic rw, input logic [3:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", req_ready, 1);
        @(posedge clk);
        exp_iss.push_back(ent_t'{rw, a, d});
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || exp_iss.size() != 0 || pend_rd || exp_next) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", n < 1000, 1);
    endtask

    task automatic rand_traffic(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            send(1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), 8'($urandom_range(255, 0)));
            if ($urandom_range(3, 0) == 0) begin
                idle();
                repeat ($urandom_range(4, 0)) @(negedge clk);
            end
        end
        idle();
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mc", {mc_start, mc_rw, mc_addr, mc_data_in}, 0);
        chk("rst_rsp", {rsp_valid, rsp_addr, rsp_rdata}, 0);
        chk("rst_terr", timeout_err, 0);

        // V1 plus first-request latency
        send(1'b0, 4'd5, 8'hAA);
        @(negedge clk);
        req_valid = 1'b0;
        chk("lat_count1", fifo_count, 1);
        chk("lat_nostart", mc_start, 0);
        @(negedge clk);
        chk("lat_start", mc_start, 1);
        chk("lat_count0", fifo_count, 0);
        chk("lat_busy", busy, 1);
        wait_idle();
        s0 = n_start;
        r0 = n_rsp;
        send(1'b1, 4'd5, 8'h00);
        idle();
        wait_idle();
        chk("v1_starts", n_start - s0, 1);
        chk("v1_rsps", n_rsp - r0, 1);
        chk("v1_addr", last_addr, 5);
        chk("v1_data", last_data, 8'hAA);

        // Define every SRAM word, then random traffic
        for (int a = 0; a < 16; a++) send(1'b0, 4'(a), 8'($urandom_range(255, 0)));
        idle();
        wait_idle();
        rand_traffic(40);
        chk("rand_no_abort", timeout_err, 0);

        // V2: slow blocker keeps the queue from draining
        ctl_lat = 10;
        send(1'b1, 4'd9, 8'h00);
        for (int i = 0; i < 4; i++) send(1'b0, 4'(i), 8'h10 + 8'(i));
        @(negedge clk);
        ctl_lat   = 3;
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_addr  = 4'd2;
        req_wdata = 8'h00;
        chk("v2_full", fifo_count, 4);
        chk("v2_ready", req_ready, 0);
        @(negedge clk);
        chk("v2_not_accepted", fifo_count, 4);
        // V3: held request enters on the edge after a pop frees a slot
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("v3_ready_back", req_ready, 1);
        chk("v3_popped", fifo_count, 3);
        @(posedge clk);
        exp_iss.push_back(ent_t'{1'b1, 4'd2, 8'h00});
        @(negedge clk);
        req_valid = 1'b0;
        chk("v3_count", fifo_count, 4);
        chk("v3_ready_low", req_ready, 0);
        wait_idle();
        chk("v3_addr", last_addr, 2);
        chk("v3_data", last_data, 8'h12);

        // V4: controller never completes the read
        ctl_hang = 1'b1;
        send(1'b1, 4'd3, 8'h00);
        send(1'b0, 4'd7, 8'h5A);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!mc_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("v4_start", mc_start, 1);
        repeat (15) @(negedge clk);
        chk("v4_before", timeout_err, 0);
        @(negedge clk);
        chk("v4_abort", timeout_err, 1);
        chk("v4_queued", fifo_count, 1);
        ctl_hang = 1'b0;
        @(negedge clk);
        chk("v4_next_start", mc_start, 1);
        chk("v4_next_addr", mc_addr, 7);
        wait_idle();
        chk("v4_sticky", timeout_err, 1);

        // V5: reset mid-WAIT with two queued; controller finishes afterwards
        ctl_lat = 10;
        send(1'b1, 4'd1, 8'h00);
        send(1'b1, 4'd2, 8'h00);
        send(1'b1, 4'd3, 8'h00);
        @(negedge clk);
        req_valid = 1'b0;
        chk("v5_queued", fifo_count, 2);
        s0 = n_start;
        r0 = n_rsp;
        @(posedge clk);
        #1 rst = 1'b1;
        exp_iss.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("v5_count", fifo_count, 0);
        chk("v5_busy", busy, 0);
        chk("v5_ready", req_ready, 1);
        chk("v5_mc", {mc_start, mc_rw, mc_addr, mc_data_in}, 0);
        chk("v5_rsp", {rsp_valid, rsp_addr, rsp_rdata}, 0);
        chk("v5_terr", timeout_err, 0);
        repeat (15) @(negedge clk);
        chk("v5_idle_after", busy, 0);
        chk("v5_no_starts", n_start - s0, 0);
        chk("v5_no_rsps", n_rsp - r0, 0);
        ctl_lat = 3;

        // V6: stray completion in IDLE
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        chk("v6_busy", busy, 0);
        @(negedge clk);
        chk("v6_busy2", busy, 0);
        chk("v6_no_start", mc_start, 0);
        chk("v6_count", fifo_count, 0);

        rand_traffic(20);
        chk("end_no_abort", timeout_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
